// File: rtl/ql_irq_pkg.sv
// Shared constants and helpers for the QL interrupt controller.
package ql_irq_pkg;

    localparam logic [2:0] REG_PEND = 3'd0;
    localparam logic [2:0] REG_MASK = 3'd1;
    localparam logic [2:0] REG_MODE = 3'd2;
    localparam logic [2:0] REG_STAT = 3'd3;
    localparam logic [2:0] REG_LOST = 3'd4;

    localparam int STAT_ANY_BIT = 15;
    localparam int STAT_ID_LSB  = 8;

    // Lowest set index wins; 0 when nothing is pending.
    function automatic logic [3:0] prio_id(input logic [15:0] pend);
        logic [3:0] id;
        id = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pend[i]) id = 4'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/ql_irq_sync.sv
// N-wide multi-stage synchroniser with a one-clk delayed copy and rise output.
module ql_irq_sync #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] src,
    output logic [N-1:0] s,
    output logic [N-1:0] s_d,
    output logic [N-1:0] rise
);

    logic [SYNC_STAGES-1:0][N-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            s_d    <= '0;
        end else begin
            sync_q[0] <= src;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            s_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;

endmodule

// File: rtl/ql_irq_ctrl.sv
// QL interrupt controller: N sources, edge/level mode, mask, W1C ack, IPL merge.
// Build option QL_IRQ_LOST_EN adds the lost-interrupt register at addr 4.
module ql_irq_ctrl
    import ql_irq_pkg::*;
#(
    parameter int          N           = 8,
    parameter int          SYNC_STAGES = 2,
    parameter int          IRQ_LEVEL   = 2,
    parameter logic [15:0] MODE_RST    = 16'h0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cen,
    input  logic [N-1:0] src,
    input  logic         sel,
    input  logic         wr,
    input  logic [2:0]   addr,
    input  logic [15:0]  din,
    output logic [15:0]  dout,
    input  logic [1:0]   ext_ipl_n,
    output logic [1:0]   ipl_n,
    output logic         irq_any
);

    logic [N-1:0] s, s_d, rise;
    logic [N-1:0] pending, pending_nxt, mask, mode;
    logic [N-1:0] rise_m, ack;
    logic         we;
    logic [1:0]   ext_lvl, int_lvl, ipl_lvl;
    logic [15:0]  pend16, mask16, mode16, lost16, stat16;
    logic         unused_din;

    ql_irq_sync #(.N(N), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .reset(reset),
        .src  (src),
        .s    (s),
        .s_d  (s_d),
        .rise (rise)
    );

    assign we         = sel & wr & cen;
    assign ack        = (we && addr == REG_PEND) ? din[N-1:0] : '0;
    assign rise_m     = rise & mask & ~mode;
    assign unused_din = ^din;

    // Set beats ack; level-mode bits simply follow the masked source.
    always_comb begin
        pending_nxt = pending;
        for (int i = 0; i < N; i++) begin
            if (mode[i])        pending_nxt[i] = s[i] & mask[i];
            else if (rise_m[i]) pending_nxt[i] = 1'b1;
            else if (ack[i])    pending_nxt[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            mask    <= '0;
            mode    <= MODE_RST[N-1:0];
        end else begin
            pending <= pending_nxt;
            if (we && addr == REG_MASK) mask <= din[N-1:0];
            if (we && addr == REG_MODE) mode <= din[N-1:0];
        end
    end

`ifdef QL_IRQ_LOST_EN
    logic [N-1:0] lost;
    logic [N-1:0] lost_clr;

    assign lost_clr = (we && addr == REG_LOST) ? din[N-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lost <= '0;
        else       lost <= (lost & ~lost_clr) | (rise_m & pending & ~ack);
    end

    assign lost16 = 16'(lost);
`else
    assign lost16 = 16'h0000;
`endif

    assign ext_lvl = ~ext_ipl_n;
    assign int_lvl = (|pending) ? 2'(IRQ_LEVEL) : 2'd0;
    assign ipl_lvl = (ext_lvl > int_lvl) ? ext_lvl : int_lvl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ipl_n   <= 2'b11;
            irq_any <= 1'b0;
        end else begin
            ipl_n   <= ~ipl_lvl;
            irq_any <= |pending;
        end
    end

    assign pend16 = 16'(pending);
    assign mask16 = 16'(mask);
    assign mode16 = 16'(mode);

    always_comb begin
        stat16 = 16'h0000;
        stat16[STAT_ANY_BIT] = irq_any;
        stat16[STAT_ID_LSB +: 4] = prio_id(pend16);
    end

    always_comb begin
        case (addr)
            REG_PEND: dout = pend16;
            REG_MASK: dout = mask16;
            REG_MODE: dout = mode16;
            REG_STAT: dout = stat16;
            REG_LOST: dout = lost16;
            default:  dout = 16'h0000;
        endcase
    end

endmodule

// File: doc/ql_irq_ctrl.md
Name: ql_irq_ctrl

Overview:
- Parametrised interrupt controller for the QL peripheral chip, and the successor to the fixed 5-source IRQ logic in the ZX8302 peripheral block.
- Provides N sources, each with per-source edge/level mode, mask, write-1-to-clear acknowledge and a priority-encoded status register.
- Merges the internal request with the IPC-driven IPL lines into the 68008 IPL inputs.
- Fully synchronous to clk: all source inputs are synchronised and edge-detected internally, with no source-clocked flops.

Parameters:
- N, 8, number of interrupt sources (1..16); source 0 has the highest priority.
- SYNC_STAGES, 2, synchroniser depth per source (≥2).
- IRQ_LEVEL, 2, 68k priority level (0..3) asserted while any unmasked interrupt is pending.
- MODE_RST, 0, reset value of the mode register (bit=1 selects level mode).

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- cen  in  1  bus clock enable; register writes are accepted only when cen=1
- src  in  N  raw interrupt sources, asynchronous, active-high
- sel  in  1  register access select
- wr  in  1  write strobe (valid with sel)
- addr  in  3  register index
- din  in  16  write data; bits [N-1:0] are used
- dout  out  16  read data, combinational from addr
- ext_ipl_n  in  2  active-low IPL request from the IPC
- ipl_n  out  2  active-low IPL to the CPU, registered
- irq_any  out  1  any unmasked pending interrupt, registered

Behaviour:
- Reset: pending=0, mask=0, mode=MODE_RST, lost=0, synchroniser and edge flops=0, ipl_n=2'b11, irq_any=0.
- Synchroniser: SYNC_STAGES flops per bit, clocked every clk independent of cen. s = synchronised value; s_d = s delayed one clk.
- Edge mode (mode[i]=0):
  - Set condition: rise[i] = s[i] & ~s_d[i] & mask[i].
  - A rise sets pending[i]. Edges occurring while mask[i]=0 are discarded.
  - Changing the mask never creates a pending bit. This is a deliberate break from the old mask-gated async behaviour.
- Level mode (mode[i]=1):
  - pending[i] = s[i] & mask[i], updated every clk.
  - Acknowledge has no effect on level-mode bits.
- Acknowledge: a write to addr 0 with cen clears pending[i] for every din[i]=1 (edge mode only).
  - Simultaneous rise and ack on the same bit: the set wins and pending stays 1.
- Mode change: switching a bit to edge mode keeps its current pending value, and s_d keeps tracking. Switching to level mode overwrites pending on the next clk.
- Register map, read and write:
  - 0: read pending, write ack (W1C).
  - 1: read/write mask.
  - 2: read/write mode.
  - 3: status, read-only: [15]=irq_any, [14:12]=0, [11:8]=id of the lowest-numbered pending bit (0 when none), [7:0]=0.
  - 4: lost; see Optional Feature.
  - 5..7: read 0, writes ignored.
  - Bits [15:N] read 0 on every register.
- Writes take effect on the clk edge where sel&wr&cen=1.
- Unselected reads: dout still decodes addr.
- IPL merge:
  - ext_lvl = ~ext_ipl_n.
  - int_lvl = IRQ_LEVEL if any pending, else 0.
  - ipl_n <= ~max(ext_lvl, int_lvl), registered.
- Latency: one clk from pending to irq_any/ipl_n; SYNC_STAGES+1 clk from a src edge to pending.
- Reset mid-operation clears all state immediately and asynchronously. The first clk after release performs no edge detection, because s_d=0 and s=0.

Optional Feature:
- Macro: QL_IRQ_LOST_EN.
- When defined:
  - lost[i] is set when a rise occurs while pending[i] is already 1 and no ack for bit i arrives in the same cycle.
  - Addr 4 reads lost; a write clears it, W1C.
  - An ack that clears pending[i] does not clear lost[i].
- When undefined: no lost flops are built, addr 4 reads 0 and writes are ignored.

Decomposition:
- Package ql_irq_pkg holds:
  - register index constants REG_PEND=0, REG_MASK=1, REG_MODE=2, REG_STAT=3, REG_LOST=4;
  - STAT_ANY_BIT=15, STAT_ID_LSB=8;
  - a function prio_id(pending) returning the lowest set index.
- One sub-module: ql_irq_sync, an N-wide SYNC_STAGES-deep synchroniser with edge output.

Test Plan:
- Edge-mode set/ack:
  - Stimulus: mask=0x01, pulse src[0] for 4 clk.
  - Response: pending=0x01 after SYNC_STAGES+1 clk, irq_any=1 and ipl_n=2'b01 one clk later.
  - Then write addr0=0x01; pending=0 and ipl_n=2'b11 one clk later.
- Mask discard:
  - Stimulus: mask=0, pulse src[3], then write mask=0x08 with src[3] held high.
  - Response: pending stays 0x00.
- Level mode:
  - Stimulus: mode=0x04, mask=0x04, src[2]=1.
  - Response: pending=0x04; an ack write of 0x04 leaves it 0x04; src[2]=0 gives pending=0 after sync latency.
- Priority and IPL merge:
  - Stimulus: pending bits 5 and 1 set.
  - Response: status reads 0x8100.
  - With ext_ipl_n=2'b00: ipl_n=2'b00. With ext_ipl_n=2'b10 (level 1): ipl_n=2'b01 (level 2).
- Set/ack collision:
  - Stimulus: an edge on src[0] lands on the same clk as an ack 0x01.
  - Response: pending[0]=1.
  - With QL_IRQ_LOST_EN: lost stays 0x00, and a second edge without ack gives lost=0x01.
- Async reset:
  - Stimulus: assert reset mid-pulse with pending=0xFF and mask=0xFF.
  - Response: all registers 0 immediately, ipl_n=2'b11, no spurious pending after release.
